// File: rtl/cic_comp_fir.sv
// 5-tap symmetric CIC droop-compensation FIR with one shared MAC, one tap per cycle.
// Build option: define CIC_COMP_FIR_SAT_EN to saturate the output instead of wrapping it.
module cic_comp_fir #(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = 8,
  parameter int OUT_SHIFT  = 5
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] out,
  output logic                    out_valid,
  output logic                    overrun
);
  localparam int NTAPS = 5;
  localparam int AW    = WIDTH + COEF_WIDTH + 3;
  localparam logic signed [COEF_WIDTH-1:0] H0 = COEF_WIDTH'(-1);
  localparam logic signed [COEF_WIDTH-1:0] H1 = COEF_WIDTH'(4);
  localparam logic signed [COEF_WIDTH-1:0] H2 = COEF_WIDTH'(26);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              k_q, k_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [WIDTH-1:0] out_q, out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overrun_q, overrun_d;
  logic signed [WIDTH-1:0] x_q [NTAPS];

  logic signed [WIDTH-1:0]      tap;
  logic signed [COEF_WIDTH-1:0] coef;
  logic signed [AW-1:0]         prod;
  logic signed [WIDTH-1:0]      res;
  logic                         accept;

  // State register; reset also aborts any MAC in flight.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = MAC;
      MAC:     if (k_q == 3'd4) state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rstn && (state_q == IDLE);
    out       = out_q;
    out_valid = out_valid_q;
    overrun   = overrun_q;
  end

  assign accept = in_ready & in_valid;

  // Symmetric coefficients: tap k and tap 4-k share a value.
  always_comb begin
    tap  = x_q[0];
    coef = H0;
    unique case (k_q)
      3'd0:    begin tap = x_q[0]; coef = H0; end
      3'd1:    begin tap = x_q[1]; coef = H1; end
      3'd2:    begin tap = x_q[2]; coef = H2; end
      3'd3:    begin tap = x_q[3]; coef = H1; end
      3'd4:    begin tap = x_q[4]; coef = H0; end
      default: begin tap = x_q[0]; coef = H0; end
    endcase
  end

  assign prod = AW'(tap) * AW'(coef);

`ifdef CIC_COMP_FIR_SAT_EN
  localparam logic signed [AW-1:0] MAXV = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = ~MAXV;
  logic signed [AW-1:0] shifted;
  assign shifted = acc_q >>> OUT_SHIFT;
  always_comb begin
    if (shifted > MAXV)      res = MAXV[WIDTH-1:0];
    else if (shifted < MINV) res = MINV[WIDTH-1:0];
    else                     res = shifted[WIDTH-1:0];
  end
`else
  assign res = WIDTH'(acc_q >>> OUT_SHIFT);
`endif

  always_comb begin
    acc_d       = acc_q;
    k_d         = k_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q | (in_valid & ~in_ready);
    unique case (state_q)
      IDLE: if (in_valid) begin acc_d = '0; k_d = '0; end
      MAC:  begin acc_d = acc_q + prod; k_d = k_q + 3'd1; end
      OUT:  begin out_d = res; out_valid_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      k_q         <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NTAPS; i++) x_q[i] <= '0;
    end else begin
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      // Refused samples never touch the delay line.
      if (accept) begin
        x_q[0] <= in;
        for (int i = 1; i < NTAPS; i++) x_q[i] <= x_q[i-1];
      end
    end
  end
endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench for cic_comp_fir: an arithmetic FIR model predicts acceptance, outputs and timing.
module tb_cic_comp_fir;
  localparam int W = 8;
  localparam int SH = 5;

  logic clk = 1'b0, rstn = 1'b0, in_valid = 1'b0;
  logic signed [W-1:0] din = '0, dout;
  logic in_ready, out_valid, overrun;

  cic_comp_fir #(.WIDTH(W), .COEF_WIDTH(8), .OUT_SHIFT(SH)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in(din),
    .in_ready(in_ready), .out(dout), .out_valid(out_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0, errors = 0;
  typedef struct {int val; int edg;} exp_t;
  exp_t sb[$];
  int hist[5];
  int hc[5] = '{-1, 4, 26, 4, -1};
  int last_acc = -100;
  bit m_ovr = 1'b0;

  task automatic chk(string nm, logic signed [31:0] act, logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int narrow(int r);
`ifdef CIC_COMP_FIR_SAT_EN
    if (r > 2**(W-1) - 1) return 2**(W-1) - 1;
    if (r < -(2**(W-1))) return -(2**(W-1));
    return r;
`else
    int t = r & (2**W - 1);
    return (t >= 2**(W-1)) ? t - 2**W : t;
`endif
  endfunction

  function automatic int ref_out();
    int sum = 0;
    for (int k = 0; k < 5; k++) sum += hc[k] * hist[k];
    return narrow(sum >>> SH);
  endfunction

  // One input cycle: drive at negedge, predict readiness, model the accept/refuse at the next edge.
  task automatic step(bit v, int d);
    bit exp_rdy;
    @(negedge clk);
    in_valid = v;
    din = W'(d);
    exp_rdy = rstn && (cyc + 1 - last_acc >= 7);
    chk("in_ready", in_ready, exp_rdy);
    chk("overrun", overrun, m_ovr);
    if (v && rstn) begin
      if (exp_rdy) begin
        for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'(din);
        last_acc = cyc + 1;
        sb.push_back('{ref_out(), cyc + 1 + 6});
      end else m_ovr = 1'b1;
    end
  endtask

  task automatic do_reset(int cycles);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    in_valid = 1'b0;
    while (sb.size() > 0 && sb[sb.size()-1].edg > cyc) void'(sb.pop_back());
    for (int k = 0; k < 5; k++) hist[k] = 0;
    m_ovr = 1'b0;
    last_acc = -100;
    @(posedge clk);
    repeat (cycles) begin
      @(negedge clk);
      chk("rst_out", dout, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_in_ready", in_ready, 0);
    end
    rstn = 1'b1;
    #1 chk("in_ready_after_rst", in_ready, 1);
  endtask

  // Monitor: every out_valid must match the head of the scoreboard, on the predicted cycle.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].edg < cyc) begin
      chk("missing_out_valid", sb[0].edg, cyc);
      void'(sb.pop_front());
    end
    if (out_valid) begin
      if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_value", dout, e.val);
        chk("out_latency", cyc, e.edg);
      end
    end
  end

  int imp[5] = '{32, 0, 0, 0, 0};
  int ovf[5] = '{-128, 127, 127, 127, -128};

  initial begin
    for (int k = 0; k < 5; k++) hist[k] = 0;
    do_reset(3);
    for (int i = 0; i < 5; i++) begin step(1, imp[i]); repeat (7) step(0, 0); end
    repeat (8) begin step(1, 100); repeat (6) step(0, 0); end

    do_reset(2);
    for (int i = 0; i < 5; i++) begin step(1, ovf[i]); repeat (7) step(0, 0); end

    // Sample 3 clocks after an accept is dropped; one 7 clocks after is taken.
    step(1, 10); step(0, 0); step(0, 0); step(1, 55);
    repeat (3) step(0, 0);
    step(1, 20);
    repeat (8) step(0, 0);

    // Reset while the MAC is running.
    step(1, 77); step(0, 0); step(0, 0);
    do_reset(2);
    step(1, 32);
    repeat (7) step(0, 0);

    repeat (50) step(1, $urandom);
    repeat (8) step(0, 0);

    repeat (300) step($urandom_range(0, 9) < 4, $urandom);
    repeat (10) step(0, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
